cpu_bus_arbiter: RTL and testbench

- Shares the single external CPU memory bus between two requesters: master 0 (instruction fetch / icache) and master 1 (data / dcache behind the memory stage).
- Every master and the downstream bus use the same request/ready word protocol: request held until a one-cycle ready, `rw=1` means write.
- Registered arbitration with round-robin or fixed priority.
- A watchdog aborts transactions the downstream never completes.

---
 rtl/cpu_bus_arbiter_pkg.sv | 19 +
 rtl/cpu_bus_arbiter_pick.sv | 26 ++
 rtl/cpu_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the two-master CPU bus arbiter.
// Combinational constants only; no latency.
// No flow control of its own.
package cpu_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_t;

    // Master indices, also the value held in last_grant.
    localparam logic MASTER_FETCH = 1'b0;
    localparam logic MASTER_DATA  = 1'b1;

    // Read data returned to a master whose transaction the watchdog killed.
    localparam logic [31:0] ABORT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_bus_arbiter_pick.sv
// Two-input arbitration: turns requests plus history into a one-hot winner.
// Purely combinational, zero latency.
// No backpressure; the caller registers the winner.
module cpu_bus_arbiter_pick
    import cpu_bus_arbiter_pkg::*;
(
    input  logic [1:0] requests,
    input  logic       last_grant,
    input  logic       fixed_priority,
    output logic [1:0] winner
);

    // Single requester wins outright; a tie goes to data in fixed mode,
    // otherwise to whichever master was not served last.
    always_comb begin
        winner = requests;
        if (requests == 2'b11) begin
            if (fixed_priority || (last_grant == MASTER_FETCH)) begin
                winner = 2'b10;
            end else begin
                winner = 2'b01;
            end
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the CPU memory bus between fetch (m0) and data (m1) with a watchdog.
// Grant is registered (1 cycle request-to-bus); completion ready is combinational.
// Masters hold request until ready; non-granted master simply waits.
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 11
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_m0_request,
    input  logic        i_m0_rw,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_ready,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_request,
    input  logic        i_m1_rw,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_ready,
    output logic [31:0] o_m1_rdata,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_timeout,
    output logic [1:0]  o_grant
);

    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    // Counter value seen during the last BUSY cycle before expiry.
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST =
        TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [1:0]           grant;
    logic                 last_grant;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 timeout_flag;
    logic [1:0]           winner;

    logic                 owner_request;
    logic                 owner_rw;
    logic [31:0]          owner_address;
    logic [31:0]          owner_wdata;
    logic                 busy;
    logic                 expire;
    logic                 complete;

    cpu_bus_arbiter_pick u_pick (
        .requests       ({i_m1_request, i_m0_request}),
        .last_grant     (last_grant),
        .fixed_priority (PRIORITY_MODE != 0),
        .winner         (winner)
    );

    // Select the granted master's request fields; nothing is latched so the
    // master may update address/wdata while it waits.
    always_comb begin
        if (grant[MASTER_DATA]) begin
            owner_request = i_m1_request;
            owner_rw      = i_m1_rw;
            owner_address = i_m1_address;
            owner_wdata   = i_m1_wdata;
        end else begin
            owner_request = i_m0_request;
            owner_rw      = i_m0_rw;
            owner_address = i_m0_address;
            owner_wdata   = i_m0_wdata;
        end
    end

    assign busy     = (state == ARB_BUSY);
    // A ready in the expiry cycle wins; a dropped request never aborts.
    assign expire   = busy && owner_request && WDOG_EN && (wdog == WDOG_LAST) && !i_bus_ready;
    assign complete = busy && owner_request && (i_bus_ready || expire);

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a dropped request, a ready, or an expiry all leave BUSY.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (i_m0_request || i_m1_request) state_nxt = ARB_BUSY;
            ARB_BUSY: begin
                if (!owner_request || i_bus_ready) state_nxt = ARB_IDLE;
                else if (expire)                   state_nxt = ARB_ABORT;
            end
            ARB_ABORT: state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // Grant, fairness history, watchdog and sticky timeout flag. An aborted
    // transaction still counts as served so round-robin stays fair.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            grant        <= 2'b00;
            last_grant   <= MASTER_DATA;
            wdog         <= '0;
            timeout_flag <= 1'b0;
        end else if (state == ARB_IDLE) begin
            grant <= winner;
            wdog  <= '0;
        end else if (busy) begin
            if (complete) last_grant <= grant[MASTER_DATA];
            if (expire) timeout_flag <= 1'b1;
            if (wdog != WDOG_MAX) wdog <= wdog + 1'b1;
        end
    end

    // Outputs: bus muxed from the owner only in BUSY; ready steered to the owner.
    always_comb begin
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = 32'd0;
        o_bus_wdata   = 32'd0;
        o_m0_ready    = 1'b0;
        o_m1_ready    = 1'b0;
        o_m0_rdata    = i_bus_rdata;
        o_m1_rdata    = i_bus_rdata;
        o_grant       = 2'b00;
        if (busy) begin
            o_bus_request = owner_request;
            o_bus_rw      = owner_rw;
            o_bus_address = owner_address;
            o_bus_wdata   = owner_wdata;
            o_m0_ready    = complete && grant[MASTER_FETCH];
            o_m1_ready    = complete && grant[MASTER_DATA];
            o_grant       = grant;
            if (expire) begin
                o_m0_rdata = ABORT_RDATA;
                o_m1_rdata = ABORT_RDATA;
            end
        end
    end

    assign o_timeout = timeout_flag;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_request, m0_rw, m1_request, m1_rw, bus_ready;
    logic [31:0] m0_address, m0_wdata, m1_address, m1_wdata, bus_rdata;

    // Index 0: round-robin, TIMEOUT_CYCLES=8. Index 1: fixed priority, default watchdog.
    logic [1:0]       m0_ready, m1_ready, bus_request, bus_rw, timeout;
    logic [1:0][31:0] m0_rdata, m1_rdata, bus_address, bus_wdata;
    logic [1:0][1:0]  grant;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8), .TIMEOUT_W(4)) dut_rr (
        .i_clock(clk), .i_reset(rst),
        .i_m0_request(m0_request), .i_m0_rw(m0_rw), .i_m0_address(m0_address),
        .i_m0_wdata(m0_wdata), .o_m0_ready(m0_ready[0]), .o_m0_rdata(m0_rdata[0]),
        .i_m1_request(m1_request), .i_m1_rw(m1_rw), .i_m1_address(m1_address),
        .i_m1_wdata(m1_wdata), .o_m1_ready(m1_ready[0]), .o_m1_rdata(m1_rdata[0]),
        .o_bus_request(bus_request[0]), .o_bus_rw(bus_rw[0]),
        .o_bus_address(bus_address[0]), .o_bus_wdata(bus_wdata[0]),
        .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata),
        .o_timeout(timeout[0]), .o_grant(grant[0])
    );

    cpu_bus_arbiter #(.PRIORITY_MODE(1)) dut_fp (
        .i_clock(clk), .i_reset(rst),
        .i_m0_request(m0_request), .i_m0_rw(m0_rw), .i_m0_address(m0_address),
        .i_m0_wdata(m0_wdata), .o_m0_ready(m0_ready[1]), .o_m0_rdata(m0_rdata[1]),
        .i_m1_request(m1_request), .i_m1_rw(m1_rw), .i_m1_address(m1_address),
        .i_m1_wdata(m1_wdata), .o_m1_ready(m1_ready[1]), .o_m1_rdata(m1_rdata[1]),
        .o_bus_request(bus_request[1]), .o_bus_rw(bus_rw[1]),
        .o_bus_address(bus_address[1]), .o_bus_wdata(bus_wdata[1]),
        .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata),
        .o_timeout(timeout[1]), .o_grant(grant[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: who owns the bus (-1 = nobody), how many BUSY cycles have
    // elapsed, whether this cycle is the post-abort dead cycle, who was served last.
    int    lim[2]  = '{8, 1024};
    int    mode[2] = '{0, 1};
    string nm[2]   = '{"rr", "fp"};
    int    owner[2], age[2], last[2];
    bit    aborting[2], tmo[2], known[2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1; age[d] = 0; last[d] = 1;
            aborting[d] = 0; tmo[d] = 0; known[d] = 0;
        end
    end

    // Inputs change just after posedge, so at negedge they are the values the
    // next posedge will sample: compare now, then advance the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic logic [1:0]  rq = {m1_request, m0_request};
            automatic logic        e_req = 1'b0, e_rw = 1'b0, held = 1'b0, expire = 1'b0;
            automatic logic [31:0] e_addr = 32'd0, e_wd = 32'd0;
            automatic logic [1:0]  e_rdy = 2'b00, e_gnt = 2'b00;
            automatic logic [31:0] e_rd;
            if (owner[d] >= 0) begin
                held   = rq[owner[d]];
                e_req  = held;
                e_rw   = (owner[d] == 1) ? m1_rw : m0_rw;
                e_addr = (owner[d] == 1) ? m1_address : m0_address;
                e_wd   = (owner[d] == 1) ? m1_wdata : m0_wdata;
                e_gnt  = 2'(1 << owner[d]);
                expire = held && lim[d] != 0 && (age[d] + 1 == lim[d]) && !bus_ready;
                if (held && (bus_ready || expire)) e_rdy = e_gnt;
            end
            e_rd = expire ? 32'hFFFF_FFFF : bus_rdata;
            if (known[d]) begin
                check({nm[d], " bus_request"}, 32'(bus_request[d]), 32'(e_req));
                check({nm[d], " bus_rw"},      32'(bus_rw[d]),      32'(e_rw));
                check({nm[d], " bus_address"}, bus_address[d],      e_addr);
                check({nm[d], " bus_wdata"},   bus_wdata[d],        e_wd);
                check({nm[d], " m0_ready"},    32'(m0_ready[d]),    32'(e_rdy[0]));
                check({nm[d], " m1_ready"},    32'(m1_ready[d]),    32'(e_rdy[1]));
                check({nm[d], " grant"},       32'(grant[d]),       32'(e_gnt));
                check({nm[d], " timeout"},     32'(timeout[d]),     32'(tmo[d]));
                if (e_rdy[0]) check({nm[d], " m0_rdata"}, m0_rdata[d], e_rd);
                if (e_rdy[1]) check({nm[d], " m1_rdata"}, m1_rdata[d], e_rd);
            end
            if (rst) begin
                owner[d] = -1; age[d] = 0; last[d] = 1;
                aborting[d] = 0; tmo[d] = 0; known[d] = 1;
            end else if (aborting[d]) begin
                aborting[d] = 0;
            end else if (owner[d] >= 0) begin
                if (!held) begin
                    owner[d] = -1;
                end else if (bus_ready) begin
                    last[d] = owner[d]; owner[d] = -1;
                end else if (expire) begin
                    last[d] = owner[d]; owner[d] = -1; tmo[d] = 1; aborting[d] = 1;
                end else begin
                    age[d]++;
                end
            end else if (rq != 2'b00) begin
                if (rq == 2'b11) owner[d] = (mode[d] == 1) ? 1 : 1 - last[d];
                else             owner[d] = rq[1] ? 1 : 0;
                age[d] = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        m0_request = 0; m0_rw = 0; m0_address = 0; m0_wdata = 0;
        m1_request = 0; m1_rw = 0; m1_address = 0; m1_wdata = 0;
        bus_ready = 0; bus_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        do_reset();

        // Reset state
        settle();
        check("reset grant rr",   32'(grant[0]),       32'h0);
        check("reset busreq rr",  32'(bus_request[0]), 32'h0);
        check("reset timeout rr", 32'(timeout[0]),     32'h0);
        check("reset busreq fp",  32'(bus_request[1]), 32'h0);

        // Single read
        m0_request = 1; m0_address = 32'h0000_1000;
        tick(); settle();
        check("read busreq c1",  32'(bus_request[0]), 32'h1);
        check("read addr c1",    bus_address[0],      32'h0000_1000);
        tick(); tick();
        tick(); bus_ready = 1; bus_rdata = 32'hDEAD_BEEF; settle();
        check("read m0_ready c4", 32'(m0_ready[0]), 32'h1);
        check("read m0_rdata c4", m0_rdata[0],      32'hDEAD_BEEF);
        tick(); bus_ready = 0; m0_request = 0; settle();
        check("read grant c5", 32'(grant[0]), 32'h0);

        // Contention: rr alternates 0,1,0,1; fp always serves m1
        do_reset();
        m0_request = 1; m1_request = 1; m0_address = 32'h10; m1_address = 32'h14;
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            check($sformatf("rr grant txn%0d", k), 32'(grant[0]), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("fp grant txn%0d", k), 32'(grant[1]), 32'h2);
            tick(); bus_ready = 1; bus_rdata = 32'h100 + k; settle();
            check($sformatf("rr ready txn%0d", k), 32'({m1_ready[0], m0_ready[0]}),
                  (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("fp ready txn%0d", k), 32'({m1_ready[1], m0_ready[1]}), 32'h2);
            tick(); bus_ready = 0;
        end
        m1_request = 0;
        tick(); settle();
        check("fp grant m1 low", 32'(grant[1]), 32'h1);
        tick(); bus_ready = 1;
        tick(); bus_ready = 0; clear_inputs();

        // Write mux with m0 waiting
        do_reset();
        m1_request = 1; m1_rw = 1; m1_address = 32'h20; m1_wdata = 32'h1234_5678;
        m0_address = 32'h44;
        tick(); m0_request = 1; settle();
        check("wr bus_rw",    32'(bus_rw[0]),   32'h1);
        check("wr bus_addr",  bus_address[0],   32'h20);
        check("wr bus_wdata", bus_wdata[0],     32'h1234_5678);
        check("wr m0_ready",  32'(m0_ready[0]), 32'h0);
        tick(); m1_wdata = 32'hCAFE_F00D; settle();
        check("wr wdata follows", bus_wdata[0], 32'hCAFE_F00D);
        tick(); bus_ready = 1; settle();
        check("wr m1_ready",      32'(m1_ready[0]), 32'h1);
        check("wr m0_ready done", 32'(m0_ready[0]), 32'h0);
        tick(); bus_ready = 0; m1_request = 0;
        tick(); settle();
        check("wr then m0 addr", bus_address[0], 32'h44);
        check("wr then m0 rw",   32'(bus_rw[0]), 32'h0);
        tick(); bus_ready = 1;
        tick(); clear_inputs();

        // Watchdog expiry (rr instance, 8 cycles)
        do_reset();
        m0_request = 1; m0_address = 32'h100; bus_rdata = 32'h0000_1234;
        for (int c = 1; c < 8; c++) tick();
        tick(); settle();
        check("wd m0_ready c8",    32'(m0_ready[0]),    32'h1);
        check("wd m0_rdata c8",    m0_rdata[0],         32'hFFFF_FFFF);
        check("wd timeout c8",     32'(timeout[0]),     32'h0);
        tick(); settle();
        check("wd timeout abort",  32'(timeout[0]),     32'h1);
        check("wd busreq abort",   32'(bus_request[0]), 32'h0);
        tick(); settle();
        check("wd busreq idle",    32'(bus_request[0]), 32'h0);
        tick(); settle();
        check("wd busreq retry",   32'(bus_request[0]), 32'h1);
        tick(); bus_ready = 1; bus_rdata = 32'h55; settle();
        check("wd retry rdata",    m0_rdata[0],         32'h55);
        check("wd timeout sticky", 32'(timeout[0]),     32'h1);
        tick(); clear_inputs();

        // Ready coincident with expiry
        do_reset(); settle();
        check("wd2 timeout after reset", 32'(timeout[0]), 32'h0);
        m0_request = 1;
        for (int c = 1; c < 8; c++) tick();
        tick(); bus_ready = 1; bus_rdata = 32'h0BAD_F00D; settle();
        check("wd2 m0_ready", 32'(m0_ready[0]), 32'h1);
        check("wd2 m0_rdata", m0_rdata[0],      32'h0BAD_F00D);
        tick(); clear_inputs(); settle();
        check("wd2 no timeout", 32'(timeout[0]), 32'h0);

        // Reset mid-transaction
        do_reset();
        m0_request = 1;
        tick(); tick(); rst = 1; m1_request = 1; settle();
        check("rst busreq held", 32'(bus_request[0]), 32'h1);
        tick(); rst = 0; settle();
        check("rst busreq",  32'(bus_request[0]), 32'h0);
        check("rst grant",   32'(grant[0]),       32'h0);
        check("rst timeout", 32'(timeout[0]),     32'h0);
        tick(); settle();
        check("rst rr first", 32'(grant[0]), 32'h1);
        check("rst fp first", 32'(grant[1]), 32'h2);
        tick(); bus_ready = 1;
        tick(); clear_inputs();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
